// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// The count is held as four BCD digits, least significant (sec units) first.
package timer_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX_UNITS    = 4'd9;
  localparam digit_t BCD_MAX_SEC_TENS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  function automatic digit_t clamp_digit(input digit_t d, input digit_t lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between the countdown timer and its neighbours.
// The timer uses the slave modport; control logic drives through the master modport.
interface countdown_timer_if;
  logic       tick_1s;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       paused;
  logic       done;
  logic       alarm;

  modport master (
    output tick_1s, load, preset_min, preset_sec, start, pause, clear,
    input  min_bcd, sec_bcd, running, paused, done, alarm
  );

  modport slave (
    input  tick_1s, load, preset_min, preset_sec, start, pause, clear,
    output min_bcd, sec_bcd, running, paused, done, alarm
  );
endinterface

// File: rtl/countdown_timer_bcd_digit_dec.sv
// One BCD digit of a borrow-chained down-counter.
// On borrow_in the digit decrements; from 0 it reloads wrap and borrows onward.
module bcd_digit_dec
  import timer_pkg::*;
(
  input  digit_t digit,
  input  digit_t wrap,
  input  logic   borrow_in,
  output digit_t digit_next,
  output logic   borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        digit_next = wrap;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown driven by the 1 s tick, with a post-expiry alarm phase
// lasting ALARM_TICKS ticks (0 holds the alarm until clear).
module countdown_timer
  import timer_pkg::*;
#(
  parameter int ALARM_TICKS  = 5,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  localparam int     CNT_W        = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TICKS);
  localparam digit_t MIN_TENS_LIM = DIGIT_W'(MAX_MIN_TENS);

  state_t            state_reg, state_next;
  digit_t            digit_reg [4];
  digit_t            digit_next [4];
  digit_t            digit_dec [4];
  logic [CNT_W-1:0]  acnt_reg, acnt_next;
  logic              done_reg, done_next;
  logic              borrow_1, borrow_2, borrow_3, borrow_4;
  logic              count_zero, count_one;

  // Index 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens.
  bcd_digit_dec u_sec_units (
    .digit(digit_reg[0]), .wrap(BCD_MAX_UNITS), .borrow_in(1'b1),
    .digit_next(digit_dec[0]), .borrow_out(borrow_1)
  );
  bcd_digit_dec u_sec_tens (
    .digit(digit_reg[1]), .wrap(BCD_MAX_SEC_TENS), .borrow_in(borrow_1),
    .digit_next(digit_dec[1]), .borrow_out(borrow_2)
  );
  bcd_digit_dec u_min_units (
    .digit(digit_reg[2]), .wrap(BCD_MAX_UNITS), .borrow_in(borrow_2),
    .digit_next(digit_dec[2]), .borrow_out(borrow_3)
  );
  bcd_digit_dec u_min_tens (
    .digit(digit_reg[3]), .wrap(MIN_TENS_LIM), .borrow_in(borrow_3),
    .digit_next(digit_dec[3]), .borrow_out(borrow_4)
  );

  // A borrow out of the top digit happens exactly when every digit is zero.
  assign count_zero = borrow_4;
  assign count_one  = (digit_reg[0] == 4'd1) && (digit_reg[1] == '0) &&
                      (digit_reg[2] == '0)   && (digit_reg[3] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      acnt_reg  <= '0;
      done_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      acnt_reg  <= acnt_next;
      done_reg  <= done_next;
      for (int i = 0; i < 4; i++) digit_reg[i] <= digit_next[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    acnt_next  = acnt_reg;
    done_next  = 1'b0;
    for (int i = 0; i < 4; i++) digit_next[i] = digit_reg[i];

    if (bus.clear) begin
      state_next = ST_IDLE;
      acnt_next  = '0;
      for (int i = 0; i < 4; i++) digit_next[i] = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_PAUSED: begin
          if (bus.load) begin
            digit_next[0] = clamp_digit(bus.preset_sec[3:0], BCD_MAX_UNITS);
            digit_next[1] = clamp_digit(bus.preset_sec[7:4], BCD_MAX_SEC_TENS);
            digit_next[2] = clamp_digit(bus.preset_min[3:0], BCD_MAX_UNITS);
            digit_next[3] = clamp_digit(bus.preset_min[7:4], MIN_TENS_LIM);
          end else if (bus.start && !count_zero) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          // Pause outranks a coincident tick, which is then dropped.
          if (bus.pause) begin
            state_next = ST_PAUSED;
          end else if (bus.tick_1s && !count_zero) begin
            for (int i = 0; i < 4; i++) digit_next[i] = digit_dec[i];
            if (count_one) begin
              state_next = ST_ALARM;
              done_next  = 1'b1;
              acnt_next  = '0;
            end
          end
        end
        ST_ALARM: begin
          if (bus.tick_1s && (ALARM_TICKS != 0)) begin
            acnt_next = acnt_reg + CNT_W'(1);
            if (acnt_next == ALARM_LAST) begin
              state_next = ST_IDLE;
              acnt_next  = '0;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign bus.min_bcd = {digit_reg[3], digit_reg[2]};
  assign bus.sec_bcd = {digit_reg[1], digit_reg[0]};
  assign bus.running = (state_reg == ST_RUN);
  assign bus.paused  = (state_reg == ST_PAUSED);
  assign bus.alarm   = (state_reg == ST_ALARM);
  assign bus.done    = done_reg;

endmodule
